// File: rtl/pipe_pkg.sv
// Shared definitions for the fetch->decode pipeline register: control state
// encoding, default field widths, bubble encoding and performance counter
// helpers.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  localparam int DEF_PC_W    = 8;
  localparam int DEF_INSTR_W = 32;
  localparam logic [DEF_INSTR_W-1:0] DEF_NOP_INSTR = '0;
  localparam int PERF_CNT_W  = 16;

  // Saturating increment for the optional performance counters.
  function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
    return (&v) ? v : v + PERF_CNT_W'(1);
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One {pc, instr} storage slot with load enable and synchronous clear.
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int PC_W    = DEF_PC_W,
  parameter int INSTR_W = DEF_INSTR_W
) (
  input  logic               clk,
  input  logic               clr_i,
  input  logic               ld_i,
  input  logic [PC_W-1:0]    pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  output logic [PC_W-1:0]    pc_o,
  output logic [INSTR_W-1:0] instr_o
);

  logic [PC_W-1:0]    pc_q;
  logic [INSTR_W-1:0] instr_q;

  // Slot storage: clear wins over load, otherwise hold.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      pc_q    <= '0;
      instr_q <= '0;
    end else if (ld_i) begin
      pc_q    <= pc_i;
      instr_q <= instr_i;
    end
  end

  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Fetch->decode pipeline register with a 2-entry skid buffer.
// Handshake: a transfer happens on a side exactly when valid and ready are
// both high at a rising edge; in_ready is a register (no combinational path
// from out_ready/stall), stall behaves as out_ready=0, flush drops everything
// held plus the incoming entry, while a same-cycle output take still counts.
// Optional build macro PIPE_STAGE_PERF_EN adds stall/flush/bubble counters.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int PC_W    = DEF_PC_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               stall,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [1:0]         dbg_state
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] stall_cnt,
  output logic [PERF_CNT_W-1:0] flush_cnt,
  output logic [PERF_CNT_W-1:0] bubble_cnt
`endif
);

  state_e state_q, state_d;
  logic   in_ready_q;
  logic   acc, take;
  logic   main_ld, main_from_skid, skid_ld;

  logic [PC_W-1:0]    main_pc, skid_pc, main_pc_d;
  logic [INSTR_W-1:0] main_instr, skid_instr, main_instr_d;

  assign acc  = in_valid & in_ready_q;
  assign take = out_valid & out_ready & ~stall;

  // State register plus registered in_ready derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_SKID);
    end
  end

  // Next state and slot load controls; flush overrides all loads.
  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (acc) begin
          state_d = ST_FULL;
          main_ld = 1'b1;
        end
      end
      ST_FULL: begin
        if (take && acc) begin
          main_ld = 1'b1;
        end else if (take) begin
          state_d = ST_EMPTY;
        end else if (acc) begin
          state_d = ST_SKID;
          skid_ld = 1'b1;
        end
      end
      ST_SKID: begin
        if (take) begin
          state_d        = ST_FULL;
          main_ld        = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d = ST_EMPTY;
      main_ld = 1'b0;
      skid_ld = 1'b0;
    end
  end

  assign main_pc_d    = main_from_skid ? skid_pc    : in_pc;
  assign main_instr_d = main_from_skid ? skid_instr : in_instr;

  pipe_entry_reg #(.PC_W(PC_W), .INSTR_W(INSTR_W)) u_main (
    .clk     (clk),
    .clr_i   (rst),
    .ld_i    (main_ld),
    .pc_i    (main_pc_d),
    .instr_i (main_instr_d),
    .pc_o    (main_pc),
    .instr_o (main_instr)
  );

  pipe_entry_reg #(.PC_W(PC_W), .INSTR_W(INSTR_W)) u_skid (
    .clk     (clk),
    .clr_i   (rst),
    .ld_i    (skid_ld),
    .pc_i    (in_pc),
    .instr_i (in_instr),
    .pc_o    (skid_pc),
    .instr_o (skid_instr)
  );

  // Outputs: main slot is the head; bubble instruction when empty, PC keeps last load.
  always_comb begin
    out_valid = (state_q != ST_EMPTY);
    out_pc    = main_pc;
    out_instr = out_valid ? main_instr : NOP_INSTR;
    in_ready  = in_ready_q;
    dbg_state = state_q;
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [PERF_CNT_W-1:0] stall_cnt_q, flush_cnt_q, bubble_cnt_q;

  // Saturating event counters, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (out_valid && stall) stall_cnt_q  <= sat_inc(stall_cnt_q);
      if (flush)              flush_cnt_q  <= sat_inc(flush_cnt_q);
      if (!out_valid)         bubble_cnt_q <= sat_inc(bubble_cnt_q);
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
